kat_adc_phase_cal: RTL and testbench
====================================

# kat_adc_phase_cal

Sampling-phase calibration sequencer for the KAT ADC capture path. Drives the ADC controller MMCM dynamic phase-shift port (`mmcm_psen`/`mmcm_psincdec`/`mmcm_psdone`) and sweeps the capture clock across a full phase range. At each step it samples a pattern-check flag, finds the longest contiguous good window, and seeks the MMCM back to that window's centre. It sits in the control fabric beside the KAT ADC interface wrapper and clocks on `mmcm_psclk`. `data_good` is already synchronised to this clock by the caller.

## Interface
- `STEPS`, 448: phase positions swept (0..STEPS-1); STEPS-1 increments per sweep.
- `STEP_W`, 10: width of position counters; 2^STEP_W > STEPS.
- `DWELL`, 64: cycles `data_good` is sampled at each position.
- `TIMEOUT`, 255: max cycles from `mmcm_psen` pulse to `mmcm_psdone`.

Ports:
- `mmcm_psclk  in  1`: clock. One clock; all logic on rising edge.
- `ctrl_reset  in  1`: synchronous, active-high reset.
- `cal_start  in  1`: start pulse. Honoured only in IDLE, DONE or FAIL.
- `ctrl_mmcm_locked  in  1`: MMCM lock.
- `data_good  in  1`: capture pattern matches this cycle.
- `mmcm_psdone  in  1`: phase-shift complete, 1-cycle pulse.
- `mmcm_psen  out  1`: phase-shift request, 1-cycle pulse.
- `mmcm_psincdec  out  1`: 1 = increment, 0 = decrement. Valid with `mmcm_psen`.
- `cal_busy  out  1`: sequence in progress.
- `cal_done  out  1`: level; successful completion.
- `cal_fail  out  1`: level; aborted.
- `cal_phase  out  STEP_W`: current position relative to the start of the sweep.
- `win_start  out  STEP_W`: first position of the best window.
- `win_len  out  STEP_W`: length of the best window in positions.

## Operation
- States: IDLE, WAIT_LOCK, DWELL, STEP, WAIT_DONE, SEEK, DONE, FAIL.
- **Start:** IDLE/DONE/FAIL + `cal_start` → WAIT_LOCK. On this transition, clear `cal_phase`, the window registers, the run tracker, `cal_done` and `cal_fail`.
- **WAIT_LOCK → DWELL** when `ctrl_mmcm_locked` = 1. Waits indefinitely otherwise.
- **DWELL:** count DWELL cycles. The position is "good" iff `data_good` = 1 on every one of those cycles. On the last dwell cycle, update the run tracker:
  - Good position: extend the current run, or start one at `cal_phase`.
  - Bad position: close the current run.
  - When a run closes (bad position or end of sweep), replace best if run length > `win_len`. Ties keep the earlier window.
- **After the last dwell cycle:** if `cal_phase` < STEPS-1 → STEP. Otherwise close any open run and evaluate:
  - `win_len` = 0 → FAIL.
  - Else target = `win_start` + floor(`win_len`/2). Go to SEEK.
- **STEP:** `mmcm_psen` = 1 for one cycle; `mmcm_psincdec` = 1 in sweep, 0 in seek. Then → WAIT_DONE.
- **WAIT_DONE:** on `mmcm_psdone`, `cal_phase` ±1. Next state is DWELL in sweep, SEEK in seek. If `mmcm_psdone` is absent for TIMEOUT cycles → FAIL.
- **SEEK:** `cal_phase` = target → DONE. Otherwise → STEP with decrement.
- **Runs** do not wrap from STEPS-1 to 0.
- **Lock loss** (`ctrl_mmcm_locked` = 0) in DWELL, STEP, WAIT_DONE or SEEK → FAIL on the next edge.
- `cal_start` while busy: ignored.
- `mmcm_psdone` outside WAIT_DONE: ignored.
- **DONE/FAIL:** hold all outputs; `mmcm_psen` = 0.
- **Reset mid-operation:** immediate return to IDLE. No completion of an outstanding shift is awaited.

## Timing
- **Reset values:** all outputs 0 and state IDLE, one edge after `ctrl_reset` is sampled high.
- **All outputs registered.**
- `cal_start` sampled at edge t → `cal_busy` = 1 from t+1.
- With lock high, first dwell cycle at t+2.
- Last dwell cycle at edge d → `mmcm_psen` high for cycle d+1, and is never asserted again until `mmcm_psdone` is received.
- `mmcm_psdone` at edge p → `cal_phase` updated and DWELL/SEEK entered at p+1.
- SEEK to STEP takes one cycle per decrement.
- DONE/FAIL entered → `cal_busy` = 0, and `cal_done`/`cal_fail` = 1, on the same edge.
- **Widths:** target is computed in STEP_W bits. `win_start` + floor(`win_len`/2) ≤ STEPS-1 always, so no overflow.
- **Shift counts:** a full sweep issues exactly STEPS-1 increments. Seek issues (STEPS-1 − target) decrements.

## Test plan
Bench parameters: STEPS=16, DWELL=4, TIMEOUT=8, MMCM model returns `mmcm_psdone` 3 cycles after `mmcm_psen`.
- **Reset:** assert `ctrl_reset` mid-sweep → all outputs 0 next cycle. A late `mmcm_psdone` is ignored, and `cal_phase` stays 0.
- **Single window:** `data_good` high at positions 5..10 → 15 increments, `win_start`=5, `win_len`=6, 7 decrements, `cal_phase`=8, `cal_done`=1.
- **Tie and full window:** windows 2..4 and 9..11 → `win_start`=2, `win_len`=3, final `cal_phase`=3. Always good → `win_start`=0, `win_len`=16, final `cal_phase`=8.
- **Glitch:** `data_good` low for 1 of 4 dwell cycles at position 7 within 5..10 → best window 8..10, `win_len`=3, `cal_phase`=9.
- **No window:** `data_good` always low → `cal_fail`=1 after 15 increments, `cal_phase`=15, no decrements.
- **Faults:**
  - Withhold `mmcm_psdone` after 3rd pulse → `cal_fail` 8 cycles later, no further `mmcm_psen`.
  - Drop lock during dwell → `cal_fail` next cycle.
  - `cal_start` while busy → no effect.

Source files
------------

// File: rtl/kat_adc_phase_cal.sv
// Sampling-phase calibration sequencer: sweeps the ADC capture clock through the MMCM
// dynamic phase-shift port, finds the longest good window and seeks back to its centre.
module kat_adc_phase_cal #(
   parameter int STEPS   = 448,
   parameter int STEP_W  = 10,
   parameter int DWELL   = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              mmcm_psclk,
   input  logic              ctrl_reset,
   input  logic              cal_start,
   input  logic              ctrl_mmcm_locked,
   input  logic              data_good,
   input  logic              mmcm_psdone,
   output logic              mmcm_psen,
   output logic              mmcm_psincdec,
   output logic              cal_busy,
   output logic              cal_done,
   output logic              cal_fail,
   output logic [STEP_W-1:0] cal_phase,
   output logic [STEP_W-1:0] win_start,
   output logic [STEP_W-1:0] win_len
);

   localparam int DWELL_W = $clog2(DWELL + 1);
   localparam int TO_W    = $clog2(TIMEOUT + 1);

   localparam logic [STEP_W-1:0]  LAST_POS   = STEP_W'(STEPS - 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_LOCK,
      ST_DWELL,
      ST_STEP,
      ST_WAIT_DONE,
      ST_SEEK,
      ST_DONE,
      ST_FAIL
   } state_t;

   state_t              state;
   logic                seek_mode;
   logic [DWELL_W-1:0]  dwell_cnt;
   logic                good_acc;
   logic [TO_W-1:0]     wait_cnt;
   logic                run_open;
   logic [STEP_W-1:0]   run_start;
   logic [STEP_W-1:0]   run_len;
   logic [STEP_W-1:0]   target;

   logic                pos_good;
   logic                last_pos;
   logic                lock_lost;
   logic                run_open_nx;
   logic [STEP_W-1:0]   run_start_nx;
   logic [STEP_W-1:0]   run_len_nx;
   logic [STEP_W-1:0]   cand_len;
   logic [STEP_W-1:0]   win_start_nx;
   logic [STEP_W-1:0]   win_len_nx;
   logic [STEP_W-1:0]   target_nx;

   // Run tracker and best-window update as seen on the last dwell cycle of a position.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no latch is inferred.
      pos_good     = good_acc & data_good;
      last_pos     = (cal_phase == LAST_POS);
      lock_lost    = !ctrl_mmcm_locked &&
                     (state inside {ST_DWELL, ST_STEP, ST_WAIT_DONE, ST_SEEK});
      run_open_nx  = pos_good;
      run_start_nx = (pos_good && !run_open) ? cal_phase : run_start;
      run_len_nx   = run_len;
      if (pos_good) begin
         run_len_nx = run_open ? run_len + STEP_W'(1) : STEP_W'(1);
      end

      // A run closes on a bad position, or at the end of the sweep while still open.
      cand_len = '0;
      if (pos_good && last_pos) begin
         cand_len = run_len_nx;
      end else if (!pos_good && run_open) begin
         cand_len = run_len;
      end

      // Strictly longer only, so a tie keeps the earlier window.
      win_start_nx = win_start;
      win_len_nx   = win_len;
      if (cand_len > win_len) begin
         win_start_nx = run_start_nx;
         win_len_nx   = cand_len;
      end
      target_nx = win_start_nx + (win_len_nx >> 1);
   end

   always_ff @(posedge mmcm_psclk) begin
      if (ctrl_reset) begin
         state         <= ST_IDLE;
         seek_mode     <= 1'b0;
         dwell_cnt     <= '0;
         good_acc      <= 1'b0;
         wait_cnt      <= '0;
         run_open      <= 1'b0;
         run_start     <= '0;
         run_len       <= '0;
         target        <= '0;
         mmcm_psen     <= 1'b0;
         mmcm_psincdec <= 1'b0;
         cal_busy      <= 1'b0;
         cal_done      <= 1'b0;
         cal_fail      <= 1'b0;
         cal_phase     <= '0;
         win_start     <= '0;
         win_len       <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge value.
         mmcm_psen <= 1'b0;
         if (lock_lost) begin
            state    <= ST_FAIL;
            cal_busy <= 1'b0;
            cal_fail <= 1'b1;
         end else begin
            unique case (state)
               ST_IDLE, ST_DONE, ST_FAIL: begin
                  if (cal_start) begin
                     state     <= ST_WAIT_LOCK;
                     seek_mode <= 1'b0;
                     cal_busy  <= 1'b1;
                     cal_done  <= 1'b0;
                     cal_fail  <= 1'b0;
                     cal_phase <= '0;
                     win_start <= '0;
                     win_len   <= '0;
                     run_open  <= 1'b0;
                     run_start <= '0;
                     run_len   <= '0;
                  end
               end

               ST_WAIT_LOCK: begin
                  if (ctrl_mmcm_locked) begin
                     state     <= ST_DWELL;
                     dwell_cnt <= '0;
                     good_acc  <= 1'b1;
                  end
               end

               ST_DWELL: begin
                  if (dwell_cnt != DWELL_LAST) begin
                     dwell_cnt <= dwell_cnt + DWELL_W'(1);
                     good_acc  <= pos_good;
                  end else begin
                     run_open  <= run_open_nx && !last_pos;
                     run_start <= run_start_nx;
                     run_len   <= run_len_nx;
                     win_start <= win_start_nx;
                     win_len   <= win_len_nx;
                     if (!last_pos) begin
                        state         <= ST_STEP;
                        mmcm_psen     <= 1'b1;
                        mmcm_psincdec <= 1'b1;
                     end else if (win_len_nx == '0) begin
                        state    <= ST_FAIL;
                        cal_busy <= 1'b0;
                        cal_fail <= 1'b1;
                     end else begin
                        state     <= ST_SEEK;
                        seek_mode <= 1'b1;
                        target    <= target_nx;
                     end
                  end
               end

               // mmcm_psen is already high for this one cycle; it drops by default.
               ST_STEP: begin
                  state    <= ST_WAIT_DONE;
                  wait_cnt <= '0;
               end

               ST_WAIT_DONE: begin
                  if (mmcm_psdone) begin
                     if (seek_mode) begin
                        cal_phase <= cal_phase - STEP_W'(1);
                        state     <= ST_SEEK;
                     end else begin
                        cal_phase <= cal_phase + STEP_W'(1);
                        state     <= ST_DWELL;
                        dwell_cnt <= '0;
                        good_acc  <= 1'b1;
                     end
                  end else if (wait_cnt == TO_LAST) begin
                     state    <= ST_FAIL;
                     cal_busy <= 1'b0;
                     cal_fail <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt + TO_W'(1);
                  end
               end

               ST_SEEK: begin
                  if (cal_phase == target) begin
                     state    <= ST_DONE;
                     cal_busy <= 1'b0;
                     cal_done <= 1'b1;
                  end else begin
                     state         <= ST_STEP;
                     mmcm_psen     <= 1'b1;
                     mmcm_psincdec <= 1'b0;
                  end
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_kat_adc_phase_cal.sv
// Bench for kat_adc_phase_cal: an MMCM phase-shift model drives data_good from its own
// absolute phase, and each calibration is compared against a best-window reference.
module tb_kat_adc_phase_cal;

   localparam int STEPS   = 16;
   localparam int STEP_W  = 5;
   localparam int DWELL   = 4;
   localparam int TIMEOUT = 8;
   localparam int PS_LAT  = 3;

   logic              mmcm_psclk       = 1'b0;
   logic              ctrl_reset       = 1'b1;
   logic              cal_start        = 1'b0;
   logic              ctrl_mmcm_locked = 1'b1;
   logic              data_good;
   logic              mmcm_psdone      = 1'b0;
   logic              mmcm_psen;
   logic              mmcm_psincdec;
   logic              cal_busy;
   logic              cal_done;
   logic              cal_fail;
   logic [STEP_W-1:0] cal_phase;
   logic [STEP_W-1:0] win_start;
   logic [STEP_W-1:0] win_len;

   int total = 0;
   int bad   = 0;

   kat_adc_phase_cal #(
      .STEPS  (STEPS),
      .STEP_W (STEP_W),
      .DWELL  (DWELL),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .mmcm_psclk      (mmcm_psclk),
      .ctrl_reset      (ctrl_reset),
      .cal_start       (cal_start),
      .ctrl_mmcm_locked(ctrl_mmcm_locked),
      .data_good       (data_good),
      .mmcm_psdone     (mmcm_psdone),
      .mmcm_psen       (mmcm_psen),
      .mmcm_psincdec   (mmcm_psincdec),
      .cal_busy        (cal_busy),
      .cal_done        (cal_done),
      .cal_fail        (cal_fail),
      .cal_phase       (cal_phase),
      .win_start       (win_start),
      .win_len         (win_len)
   );

   always #5 mmcm_psclk = ~mmcm_psclk;

   // MMCM model: absolute phase position, psdone PS_LAT cycles after a request.
   int pos         = 0;
   int inc_total   = 0;
   int dec_total   = 0;
   int psen_total  = 0;
   int done_total  = 0;
   int since_move  = 0;
   int pend_cnt    = 0;
   bit pend_inc    = 1'b0;
   int withhold_at = 1 << 30;

   always @(posedge mmcm_psclk) begin
      mmcm_psdone <= 1'b0;
      since_move  <= since_move + 1;
      if (pend_cnt == 1) begin
         mmcm_psdone <= 1'b1;
         pos         <= pend_inc ? pos + 1 : pos - 1;
         since_move  <= 0;
         done_total  <= done_total + 1;
      end
      if (pend_cnt != 0) pend_cnt <= pend_cnt - 1;
      if (mmcm_psen) begin
         psen_total <= psen_total + 1;
         if (mmcm_psincdec) inc_total <= inc_total + 1;
         else               dec_total <= dec_total + 1;
         if (psen_total + 1 < withhold_at) begin
            pend_cnt <= PS_LAT - 1;
            pend_inc <= mmcm_psincdec;
         end
      end
   end

   // Capture eye, relative to the phase at which the current calibration began.
   logic [STEPS-1:0] mask_q     = '0;
   int               base       = 0;
   int               glitch_pos = -1;
   int               glitch_k   = 0;
   int               rel;
   logic [3:0]       rel_idx;

   always_comb begin
      rel       = pos - base;
      rel_idx   = 4'(rel);
      data_good = 1'b0;
      if (rel >= 0 && rel < STEPS)
         data_good = mask_q[rel_idx] && !(rel == glitch_pos && since_move == glitch_k);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge mmcm_psclk);
      cal_start = 1'b1;
      @(negedge mmcm_psclk);
      cal_start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_psen"},     mmcm_psen,     0);
      check({tag, "_psincdec"}, mmcm_psincdec, 0);
      check({tag, "_busy"},     cal_busy,      0);
      check({tag, "_done"},     cal_done,      0);
      check({tag, "_fail"},     cal_fail,      0);
      check({tag, "_phase"},    cal_phase,     0);
      check({tag, "_wstart"},   win_start,     0);
      check({tag, "_wlen"},     win_len,       0);
   endtask

   // Full calibration against the reference: longest run of good positions, earliest on ties.
   task automatic run_cal(input string name, input logic [STEPS-1:0] mask, input int gpos,
                          input int gk, input bit poke_start, input int lock_delay);
      logic [STEPS-1:0] eff;
      int bs, bl, cur, tgt, n, inc0, dec0, psen0;
      bit exp_fail;

      eff = mask;
      if (gpos >= 0) eff[gpos] = 1'b0;
      bs = 0; bl = 0; cur = 0;
      for (int p = 0; p < STEPS; p++) begin
         cur = eff[p] ? cur + 1 : 0;
         if (cur > bl) begin
            bl = cur;
            bs = p - cur + 1;
         end
      end
      exp_fail = (bl == 0);
      tgt      = bs + bl / 2;

      mask_q     = mask;
      glitch_pos = gpos;
      glitch_k   = gk;
      base       = pos;
      inc0       = inc_total;
      dec0       = dec_total;
      psen0      = psen_total;
      if (lock_delay > 0) ctrl_mmcm_locked = 1'b0;

      pulse_start();
      check({name, "_busy_start"}, cal_busy, 1);
      if (lock_delay > 0) begin
         repeat (lock_delay) @(negedge mmcm_psclk);
         check({name, "_lockwait_busy"}, cal_busy, 1);
         check({name, "_lockwait_psen"}, psen_total - psen0, 0);
         ctrl_mmcm_locked = 1'b1;
      end

      n = 0;
      while (!(cal_done || cal_fail) && n < 3000) begin
         @(negedge mmcm_psclk);
         n++;
         if (poke_start && n == 40) begin
            cal_start = 1'b1;
            @(negedge mmcm_psclk);
            cal_start = 1'b0;
            n++;
         end
      end

      check({name, "_done"},   cal_done,  !exp_fail);
      check({name, "_fail"},   cal_fail,  exp_fail);
      check({name, "_busy"},   cal_busy,  0);
      check({name, "_wstart"}, win_start, exp_fail ? 0 : bs);
      check({name, "_wlen"},   win_len,   bl);
      check({name, "_phase"},  cal_phase, exp_fail ? STEPS - 1 : tgt);
      check({name, "_incs"},   inc_total - inc0, STEPS - 1);
      check({name, "_decs"},   dec_total - dec0, exp_fail ? 0 : STEPS - 1 - tgt);
      repeat (4) @(negedge mmcm_psclk);
      check({name, "_psen_quiet"}, psen_total - psen0,
            exp_fail ? STEPS - 1 : 2 * (STEPS - 1) - tgt);
      check({name, "_phase_hold"}, cal_phase, exp_fail ? STEPS - 1 : tgt);
      glitch_pos = -1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, k, psen0, done0;

      // Power-on reset
      ctrl_reset = 1'b1;
      repeat (3) @(negedge mmcm_psclk);
      check_all_zero("por");
      ctrl_reset = 1'b0;
      repeat (2) @(negedge mmcm_psclk);
      check_all_zero("idle");

      // Reset mid-sweep with a phase shift outstanding
      mask_q = 16'h07E0;
      base   = pos;
      psen0  = psen_total;
      pulse_start();
      n = 0;
      while (psen_total == psen0 && n < 200) begin
         @(negedge mmcm_psclk);
         n++;
      end
      check("rst_first_req", psen_total - psen0, 1);
      ctrl_reset = 1'b1;
      @(negedge mmcm_psclk);
      check_all_zero("rst_mid");
      ctrl_reset = 1'b0;
      repeat (6) @(negedge mmcm_psclk);
      check("rst_late_phase", cal_phase, 0);
      check("rst_late_busy",  cal_busy,  0);
      check("rst_late_psen",  psen_total - psen0, 1);

      // Directed windows
      run_cal("single", 16'h07E0, -1, 0, 1'b0, 0);
      run_cal("tie",    16'h0E1C, -1, 0, 1'b0, 0);
      run_cal("full",   16'hFFFF, -1, 0, 1'b0, 0);
      run_cal("glitch", 16'h07E0,  7, int'($urandom_range(1, DWELL)), 1'b0, 0);
      run_cal("nowin",  16'h0000, -1, 0, 1'b0, 0);
      run_cal("edge_hi", 16'hC000, -1, 0, 1'b0, 0);
      run_cal("edge_lo", 16'h0003, -1, 0, 1'b0, 0);

      // Start while busy, and an indefinite wait for lock
      run_cal("poke",     16'($urandom), -1, 0, 1'b1, 0);
      run_cal("lockwait", 16'($urandom), -1, 0, 1'b0, 10);

      // Missing psdone on the 3rd request
      mask_q      = 16'hFFFF;
      base        = pos;
      psen0       = psen_total;
      withhold_at = psen_total + 3;
      pulse_start();
      n = 0;
      while (psen_total - psen0 < 3 && n < 500) begin
         @(negedge mmcm_psclk);
         n++;
      end
      check("to_reqs", psen_total - psen0, 3);
      k = 0;
      while (!cal_fail && k < 50) begin
         @(negedge mmcm_psclk);
         k++;
      end
      check("to_cycles", k, TIMEOUT);
      check("to_busy",   cal_busy,  0);
      check("to_done",   cal_done,  0);
      check("to_phase",  cal_phase, 2);
      repeat (6) @(negedge mmcm_psclk);
      check("to_no_more_psen", psen_total - psen0, 3);
      withhold_at = 1 << 30;

      // Lock loss during dwell
      mask_q = 16'($urandom);
      base   = pos;
      done0  = done_total;
      pulse_start();
      n = 0;
      while (done_total == done0 && n < 500) begin
         @(negedge mmcm_psclk);
         n++;
      end
      @(negedge mmcm_psclk);
      ctrl_mmcm_locked = 1'b0;
      check("lock_pre_fail", cal_fail, 0);
      @(negedge mmcm_psclk);
      check("lock_fail",  cal_fail,  1);
      check("lock_busy",  cal_busy,  0);
      check("lock_psen",  mmcm_psen, 0);
      check("lock_phase", cal_phase, 1);
      ctrl_mmcm_locked = 1'b1;
      repeat (2) @(negedge mmcm_psclk);

      // Random eyes, with an occasional one-cycle glitch
      for (int r = 0; r < 6; r++) begin
         run_cal("rand", 16'($urandom), (r % 2 == 1) ? int'($urandom_range(0, STEPS - 1)) : -1,
                 int'($urandom_range(1, DWELL)), 1'b0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
